// File: rtl/modarith_ctrl_if.sv
// Bundle of host-side request/result and adder-side operand/handshake signals.
// Latency: none, wires only.
// Backpressure: none; the start/done and add_start/add_done pulses pace the traffic.
// Ports: slave = view of the sequencer, master = view of the host plus adder environment.
interface modarith_ctrl_if #(
    parameter int W = 514
);
    // host side
    logic         start;
    logic         op_sub;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] in_m;
    logic [W-1:0] result;
    logic         done;
    logic         busy;
    // adder side
    logic         add_start;
    logic         add_subtract;
    logic         add_shift;
    logic [W-1:0] add_in_a;
    logic [W-1:0] add_in_b;
    logic [W:0]   add_result;
    logic         add_done;

    modport slave (
        input  start, op_sub, in_a, in_b, in_m, add_result, add_done,
        output result, done, busy, add_start, add_subtract, add_shift, add_in_a, add_in_b
    );

    modport master (
        output start, op_sub, in_a, in_b, in_m, add_result, add_done,
        input  result, done, busy, add_start, add_subtract, add_shift, add_in_a, add_in_b
    );
endinterface

// File: rtl/modarith_ctrl.sv
// Modular add/sub sequencer: (a +/- b) mod M using two passes through a shared adder.
// Latency: 4 + L1 + L2 cycles counting the start cycle and the done cycle, data independent.
// Backpressure: start is accepted only in IDLE; requests while busy or on the done cycle are dropped.
// Ports: clk, resetn (async active-low); io_bus carries host start/op/operands/result/done/busy
//        and the adder start/subtract/shift/operands/result/done handshake.
module modarith_ctrl #(
    parameter int W = 514
) (
    input  logic                 clk,
    input  logic                 resetn,
    modarith_ctrl_if.slave       io_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP1_GO,
        S_OP1_WAIT,
        S_OP2_GO,
        S_OP2_WAIT,
        S_FIN
    } state_t;

    state_t       r_state;
    state_t       w_next;

    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_m;
    logic         r_sub;
    logic [W:0]   r_r1;
    logic [W:0]   r_r2;
    logic [W-1:0] r_result;
    // High during the first cycle of each WAIT state so a done still asserted
    // from the previous adder operation is not mistaken for the new one.
    logic         r_blank;

    logic         w_acc;
    logic [W-1:0] w_sel;
    logic         w_add_start;
    logic         w_add_subtract;
    logic [W-1:0] w_add_in_a;
    logic [W-1:0] w_add_in_b;

    assign w_acc = io_bus.add_done & ~r_blank;

    // Both candidates are always computed; the sign bit of the relevant pass
    // picks which one survives, so timing never depends on the data.
    assign w_sel = r_sub ? (r_r1[W] ? r_r2[W-1:0] : r_r1[W-1:0])
                         : (r_r2[W] ? r_r1[W-1:0] : r_r2[W-1:0]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_sub    <= 1'b0;
            r_r1     <= '0;
            r_r2     <= '0;
            r_result <= '0;
            r_blank  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_blank <= (r_state == S_OP1_GO) || (r_state == S_OP2_GO);
            if ((r_state == S_IDLE) && io_bus.start) begin
                r_a   <= io_bus.in_a;
                r_b   <= io_bus.in_b;
                r_m   <= io_bus.in_m;
                r_sub <= io_bus.op_sub;
            end
            if ((r_state == S_OP1_WAIT) && w_acc) begin
                r_r1 <= io_bus.add_result;
            end
            if ((r_state == S_OP2_WAIT) && w_acc) begin
                r_r2 <= io_bus.add_result;
            end
            if (r_state == S_FIN) begin
                r_result <= w_sel;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_add_start    = 1'b0;
        w_add_subtract = 1'b0;
        w_add_in_a     = '0;
        w_add_in_b     = '0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_next = S_OP1_GO;
                end
            end
            S_OP1_GO: begin
                w_add_start    = 1'b1;
                w_add_subtract = r_sub;
                w_add_in_a     = r_a;
                w_add_in_b     = r_b;
                w_next         = S_OP1_WAIT;
            end
            S_OP1_WAIT: begin
                w_add_subtract = r_sub;
                w_add_in_a     = r_a;
                w_add_in_b     = r_b;
                if (w_acc) begin
                    w_next = S_OP2_GO;
                end
            end
            S_OP2_GO: begin
                // Correction pass: r1-M after an add, r1+M after a subtract.
                w_add_start    = 1'b1;
                w_add_subtract = ~r_sub;
                w_add_in_a     = r_r1[W-1:0];
                w_add_in_b     = r_m;
                w_next         = S_OP2_WAIT;
            end
            S_OP2_WAIT: begin
                w_add_subtract = ~r_sub;
                w_add_in_a     = r_r1[W-1:0];
                w_add_in_b     = r_m;
                if (w_acc) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign io_bus.add_start    = w_add_start;
    assign io_bus.add_subtract = w_add_subtract;
    assign io_bus.add_shift    = 1'b0;
    assign io_bus.add_in_a     = w_add_in_a;
    assign io_bus.add_in_b     = w_add_in_b;
    assign io_bus.done         = (r_state == S_FIN);
    assign io_bus.busy         = (r_state != S_IDLE);
    // The fresh result is visible in the done cycle itself, then held.
    assign io_bus.result       = (r_state == S_FIN) ? w_sel : r_result;

endmodule

// File: doc/modarith_ctrl.md
Name: modarith_ctrl

Overview:
- Sequencer that performs modular addition and subtraction, (a ± b) mod M, on the shared multi-precision adder (add/subtract/shift, start/done handshake).
- Always issues exactly two adder operations: a main op, then a modulus correction. Timing therefore does not depend on the data, as the RSA datapath requires.
- Sits between the RSA top-level control and the adder. It owns the adder's start, subtract, shift and operand inputs while busy.

Parameters:
- W, 514, adder operand width. The adder result is W+1 bits. Operands and modulus must satisfy a, b < M < 2^(W-1).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- op_sub  in  1  0: (a+b) mod M, 1: (a-b) mod M; captured with start
- in_a  in  W  operand a; captured with start
- in_b  in  W  operand b; captured with start
- in_m  in  W  modulus M; captured with start
- result  out  W  reduced result; held until the next accepted start
- done  out  1  one-cycle pulse when result is valid
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- add_start  out  1  start pulse to the adder
- add_subtract  out  1  subtract select to the adder
- add_shift  out  1  tied 0
- add_in_a  out  W  adder operand a
- add_in_b  out  W  adder operand b
- add_result  in  W+1  adder result; bit W set means a negative subtraction result
- add_done  in  1  adder completion

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - result=0, done=0, busy=0, add_start=0, add_subtract=0, add_shift=0.
  - add_in_a=0, add_in_b=0, and all internal operand registers cleared.
- States: IDLE, OP1_GO, OP1_WAIT, OP2_GO, OP2_WAIT, FIN.
- IDLE:
  - start=1 captures a, b, M and op_sub, then moves to OP1_GO.
  - start is ignored in every other state (no queuing).
- OP1_GO (1 cycle):
  - add_start=1, add_in_a=a, add_in_b=b, add_subtract=op_sub.
  - Next state is OP1_WAIT.
- OP1_WAIT:
  - add_done is ignored during the first OP1_WAIT cycle (blanks a stale done left from the previous op).
  - Afterwards, add_done=1 latches r1=add_result[W:0] and moves to OP2_GO.
- OP2_GO (1 cycle), add_start=1:
  - Add op: add_in_a=r1[W-1:0], add_in_b=M, add_subtract=1 (computes r1-M).
  - Sub op: add_in_a=r1[W-1:0], add_in_b=M, add_subtract=0 (computes r1+M).
  - Next state is OP2_WAIT.
- OP2_WAIT:
  - Same one-cycle add_done blanking as OP1_WAIT.
  - add_done=1 latches r2=add_result, then moves to FIN.
- FIN (1 cycle), done=1, result selected as:
  - Add op: r2[W]=1 (r1<M) gives r1[W-1:0]; otherwise r2[W-1:0].
  - Sub op: r1[W]=1 (a<b) gives r2[W-1:0] (r1+M, truncated to W bits); otherwise r1[W-1:0].
  - Next state is IDLE.
- add_start is high only in the GO states. Adder operands and add_subtract stay stable from GO until the matching add_done.
- Latency from start to done = 4 + L1 + L2 cycles, where Ln is the adder cycles from add_start to add_done (each Ln ≥ 2). The count is independent of operand values and of op.
- Boundaries:
  - a+b == M gives 0.
  - a == b (sub) gives 0.
  - a+b == 2M-2 gives M-2.
  - The r2 computed but discarded is never exposed on result.
- Reset mid-operation aborts immediately to IDLE with outputs at reset values. The adder shares resetn.
- A start asserted in the same cycle as done (state FIN) is ignored. A start in the following IDLE cycle is accepted.

Test Plan:
- M=23, add 20+10 → done after 4+L1+L2 cycles, result=7; busy high throughout; exactly two add_start pulses, the second with add_subtract=1.
- M=23, add 5+6 → 11. Add 12+11 → 0. Add 22+22 → 21. The cycle count is identical for all three.
- M=23, sub 5-9 → 19. Sub 9-5 → 4. Sub 7-7 → 0. The second pulse has add_subtract=0 in all three.
- 512-bit modulus M=2^511+1, a=M-1, b=M-1, add → result=M-2. Check against the Python testvector generator.
- start re-pulsed while busy, and start asserted on the done cycle → no extra add_start and no second done. A start one cycle later → a new op completes correctly.
- resetn dropped during OP1_WAIT → all outputs 0 in the same cycle. After release, a fresh 20+10 mod 23 → 7, with no stale done accepted.
